// File: rtl/map_access_arbiter_if.sv
// Bus bundle between the map RAM arbiter, its three requesters and the RAM.
interface map_access_arbiter_if #(
  parameter int unsigned CELL_W = 4,
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROW_AW = 5,
  parameter int unsigned COL_AW = 6
);
  localparam int unsigned W = CELL_W * COLS;

  // Renderer
  logic              vid_req;
  logic [ROW_AW-1:0] vid_row;
  logic              vid_ack;
  // Pacman collision logic
  logic              pac_req;
  logic [ROW_AW-1:0] pac_row;
  logic [COL_AW-1:0] pac_col;
  logic              pac_we;
  logic [CELL_W-1:0] pac_wdata;
  logic              pac_ack;
  // Ghost mover
  logic              gh_req;
  logic [ROW_AW-1:0] gh_row;
  logic [COL_AW-1:0] gh_col;
  logic              gh_we;
  logic [CELL_W-1:0] gh_wdata;
  logic              gh_ack;
  // Shared results
  logic [W-1:0]      rd_word;
  logic [CELL_W-1:0] rd_cell;
  logic              col_err;
  // RAM side
  logic [ROW_AW-1:0] ram_addr;
  logic [W-1:0]      ram_data;
  logic              ram_wren;
  logic [W-1:0]      ram_q;

  // Arbiter side
  modport slave (
    input  vid_req, vid_row,
    input  pac_req, pac_row, pac_col, pac_we, pac_wdata,
    input  gh_req, gh_row, gh_col, gh_we, gh_wdata,
    input  ram_q,
    output vid_ack, pac_ack, gh_ack, rd_word, rd_cell, col_err,
    output ram_addr, ram_data, ram_wren
  );

  // Requesters and RAM side
  modport master (
    output vid_req, vid_row,
    output pac_req, pac_row, pac_col, pac_we, pac_wdata,
    output gh_req, gh_row, gh_col, gh_we, gh_wdata,
    output ram_q,
    input  vid_ack, pac_ack, gh_ack, rd_word, rd_cell, col_err,
    input  ram_addr, ram_data, ram_wren
  );
endinterface

// File: rtl/map_access_arbiter.sv
// Serialises renderer row reads and pacman/ghost cell read-modify-writes onto the
// single-port map RAM. Each transaction is atomic: IDLE -> ADDR -> DATA -> [WRITE] -> ACK.
module map_access_arbiter #(
  parameter int unsigned CELL_W = 4,
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROW_AW = 5,
  parameter int unsigned COL_AW = 6
) (
  input logic                 CLOCK_50,
  input logic                 reset_n,
  map_access_arbiter_if.slave bus_io
);
  localparam int unsigned W = CELL_W * COLS;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StWrite, StAck} state_e;
  typedef enum logic [1:0] {IdVid, IdPac, IdGh} req_id_e;

  state_e            state_q;
  req_id_e           id_q;
  logic [ROW_AW-1:0] row_q;
  logic [COL_AW-1:0] col_q;
  logic              we_q;
  logic [CELL_W-1:0] wdata_q;
  logic              prefer_gh_q;  // set once pac has been served, so gh wins the next tie
  logic              vid_ack_q, pac_ack_q, gh_ack_q, col_err_q;
  logic [ROW_AW-1:0] ram_addr_q;
  logic [W-1:0]      ram_data_q;
  logic              ram_wren_q;
  logic [W-1:0]      rd_word_q;
  logic [CELL_W-1:0] rd_cell_q;

  req_id_e           win_id;
  logic [ROW_AW-1:0] win_row;
  logic [COL_AW-1:0] win_col;
  logic              win_we;
  logic [CELL_W-1:0] win_wdata;
  logic              any_req;
  logic              col_ok;
  logic [CELL_W-1:0] cell_old;
  logic [W-1:0]      word_new;

  // Pick the winner: renderer first, then pac/gh round-robin.
  always_comb begin
    win_id    = IdVid;
    win_row   = bus_io.vid_row;
    win_col   = '0;
    win_we    = 1'b0;
    win_wdata = '0;
    any_req   = bus_io.vid_req | bus_io.pac_req | bus_io.gh_req;
    if (bus_io.vid_req) begin
      win_id = IdVid;
    end else if (bus_io.pac_req && (!bus_io.gh_req || !prefer_gh_q)) begin
      win_id    = IdPac;
      win_row   = bus_io.pac_row;
      win_col   = bus_io.pac_col;
      win_we    = bus_io.pac_we;
      win_wdata = bus_io.pac_wdata;
    end else if (bus_io.gh_req) begin
      win_id    = IdGh;
      win_row   = bus_io.gh_row;
      win_col   = bus_io.gh_col;
      win_we    = bus_io.gh_we;
      win_wdata = bus_io.gh_wdata;
    end
  end

  // Extract the addressed cell from the RAM word and build the modified word.
  always_comb begin
    col_ok   = (col_q < COL_AW'(COLS));
    cell_old = '0;
    word_new = bus_io.ram_q;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (col_q == COL_AW'(i)) begin
        cell_old = bus_io.ram_q[W-1-CELL_W*i -: CELL_W];
        word_new[W-1-CELL_W*i -: CELL_W] = wdata_q;
      end
    end
  end

  // Transaction sequencer with registered RAM controls and ack pulses.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      id_q        <= IdVid;
      row_q       <= '0;
      col_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      prefer_gh_q <= 1'b0;
      vid_ack_q   <= 1'b0;
      pac_ack_q   <= 1'b0;
      gh_ack_q    <= 1'b0;
      col_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      rd_word_q   <= '0;
      rd_cell_q   <= '0;
    end else begin
      vid_ack_q  <= 1'b0;
      pac_ack_q  <= 1'b0;
      gh_ack_q   <= 1'b0;
      col_err_q  <= 1'b0;
      ram_wren_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            id_q       <= win_id;
            row_q      <= win_row;
            col_q      <= win_col;
            we_q       <= win_we;
            wdata_q    <= win_wdata;
            ram_addr_q <= win_row;
            if (win_id == IdPac) prefer_gh_q <= 1'b1;
            if (win_id == IdGh)  prefer_gh_q <= 1'b0;
            state_q    <= StAddr;
          end
        end
        StAddr: state_q <= StData;
        StData: begin
          rd_word_q <= bus_io.ram_q;
          rd_cell_q <= cell_old;
          if (we_q && col_ok) begin
            ram_data_q <= word_new;
            ram_wren_q <= 1'b1;
            state_q    <= StWrite;
          end else begin
            vid_ack_q <= (id_q == IdVid);
            pac_ack_q <= (id_q == IdPac);
            gh_ack_q  <= (id_q == IdGh);
            col_err_q <= ~col_ok;
            state_q   <= StAck;
          end
        end
        StWrite: begin
          vid_ack_q <= (id_q == IdVid);
          pac_ack_q <= (id_q == IdPac);
          gh_ack_q  <= (id_q == IdGh);
          state_q   <= StAck;
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.vid_ack  = vid_ack_q;
  assign bus_io.pac_ack  = pac_ack_q;
  assign bus_io.gh_ack   = gh_ack_q;
  assign bus_io.col_err  = col_err_q;
  assign bus_io.rd_word  = rd_word_q;
  assign bus_io.rd_cell  = rd_cell_q;
  assign bus_io.ram_addr = ram_addr_q;
  assign bus_io.ram_data = ram_data_q;
  assign bus_io.ram_wren = ram_wren_q;
endmodule

// File: tb/tb_map_access_arbiter.sv
// Bench for map_access_arbiter: table vectors, corner sequences and randomized rounds
// checked against a transaction-level model of the map and the arbitration order.
module tb_map_access_arbiter;
  localparam int W = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  map_access_arbiter_if bus ();

  map_access_arbiter u_dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus_io   (bus)
  );

  // RAM model: registered read, write on wren, plus a preload path for the bench.
  logic [W-1:0] mem [32];
  logic         pl_en = 1'b0;
  logic [4:0]   pl_row = '0;
  logic [W-1:0] pl_word = '0;
  always @(posedge clk) begin
    bus.ram_q <= mem[bus.ram_addr];
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
    if (pl_en) mem[pl_row] <= pl_word;
  end

  int total = 0;
  int bad = 0;

  logic [W-1:0] ref_mem [32];
  logic [4:0]   r_row [3];
  logic [5:0]   r_col [3];
  bit           r_we  [3];
  logic [3:0]   r_wd  [3];
  int           ack_cyc  [3];
  logic [3:0]   ack_cell [3];
  bit           ack_err  [3];
  int           wr_seen;
  bit           rr_last_pac;

  typedef struct {
    int who; int row; int col; bit we; int wd; int pre;
    int exp_cell; bit exp_err; int exp_lat; int exp_wr;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] get_cell(input logic [W-1:0] w, input int c);
    if (c >= 40) return 4'h0;
    return w[W-1-4*c -: 4];
  endfunction

  function automatic logic [W-1:0] set_cell(input logic [W-1:0] w, input int c,
                                            input logic [3:0] v);
    logic [W-1:0] r;
    r = w;
    if (c < 40) r[W-1-4*c -: 4] = v;
    return r;
  endfunction

  function automatic bit eff_write(input int wid);
    return (wid != 0) && r_we[wid] && (r_col[wid] < 6'd40);
  endfunction

  task automatic preload(input int row, input logic [W-1:0] word);
    ref_mem[row] = word;
    pl_row = 5'(row);
    pl_word = word;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic clear_reqs();
    bus.vid_req = 1'b0;
    bus.pac_req = 1'b0;
    bus.gh_req  = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    rr_last_pac = 1'b0;
  endtask

  // Raise the enabled requesters together, hold each until its own ack, check every ack.
  task automatic run_round(input bit en_v, input bit en_p, input bit en_g);
    int order[$];
    int exp_cyc[$];
    int t, k, n, exp_wr, who, wid, nack;
    if (en_v) order.push_back(0);
    if (en_p && en_g) begin
      if (rr_last_pac) begin order.push_back(2); order.push_back(1); end
      else begin order.push_back(1); order.push_back(2); end
    end else if (en_p) order.push_back(1);
    else if (en_g) order.push_back(2);
    n = order.size();
    t = 0;
    exp_wr = 0;
    for (int i = 0; i < n; i++) begin
      t += ((i == 0) ? 3 : 4) + (eff_write(order[i]) ? 1 : 0);
      exp_cyc.push_back(t);
      exp_wr += eff_write(order[i]) ? 1 : 0;
      if (order[i] == 1) rr_last_pac = 1'b1;
      if (order[i] == 2) rr_last_pac = 1'b0;
    end
    bus.vid_row = r_row[0];
    bus.pac_row = r_row[1]; bus.pac_col = r_col[1]; bus.pac_we = r_we[1]; bus.pac_wdata = r_wd[1];
    bus.gh_row  = r_row[2]; bus.gh_col  = r_col[2]; bus.gh_we  = r_we[2]; bus.gh_wdata  = r_wd[2];
    bus.vid_req = en_v;
    bus.pac_req = en_p;
    bus.gh_req  = en_g;
    k = 0;
    wr_seen = 0;
    for (int c = 1; c <= 40 && k < n; c++) begin
      tick();
      if (bus.ram_wren) wr_seen++;
      nack = int'(bus.vid_ack) + int'(bus.pac_ack) + int'(bus.gh_ack);
      if (nack > 1) check("single_ack", nack, 1);
      else if (nack == 1) begin
        who = bus.vid_ack ? 0 : (bus.pac_ack ? 1 : 2);
        wid = order[k];
        check("ack_who", who, wid);
        check("ack_cycle", c, exp_cyc[k]);
        check("rd_word", bus.rd_word, ref_mem[r_row[wid]]);
        if (wid != 0) begin
          check("rd_cell", bus.rd_cell, get_cell(ref_mem[r_row[wid]], r_col[wid]));
          check("col_err", bus.col_err, r_col[wid] >= 6'd40);
        end else begin
          check("col_err_vid", bus.col_err, 0);
        end
        ack_cyc[wid]  = c;
        ack_cell[wid] = bus.rd_cell;
        ack_err[wid]  = bus.col_err;
        if (eff_write(wid)) ref_mem[r_row[wid]] = set_cell(ref_mem[r_row[wid]], r_col[wid], r_wd[wid]);
        if (who == 0) bus.vid_req = 1'b0;
        if (who == 1) bus.pac_req = 1'b0;
        if (who == 2) bus.gh_req = 1'b0;
        k++;
      end
    end
    if (k < n) check("round_timeout", k, n);
    clear_reqs();
    tick();
    if (bus.ram_wren) wr_seen++;
    check("wren_cycles", wr_seen, exp_wr);
  endtask

  initial begin
    int who_seq[$];
    int cyc_seq[$];
    int pac_acks, pac_cyc;
    int en;
    clear_reqs();
    bus.vid_row = '0; bus.pac_row = '0; bus.pac_col = '0; bus.pac_we = 1'b0; bus.pac_wdata = '0;
    bus.gh_row = '0; bus.gh_col = '0; bus.gh_we = 1'b0; bus.gh_wdata = '0;

    vecs[0] = '{1, 3, 5, 1, 0, 2, 2, 0, 4, 1};
    vecs[1] = '{2, 7, 0, 1, 9, 4, 4, 0, 4, 1};
    vecs[2] = '{2, 7, 39, 0, 1, 15, 15, 0, 3, 0};
    vecs[3] = '{2, 10, 40, 1, 5, 0, 0, 1, 3, 0};
    vecs[4] = '{0, 3, 0, 0, 0, 6, 0, 0, 3, 0};
    vecs[5] = '{1, 31, 63, 1, 7, 0, 0, 1, 3, 0};
    vecs[6] = '{1, 0, 39, 1, 15, 0, 0, 0, 4, 1};

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_vid_ack", bus.vid_ack, 0);
    check("rst_pac_ack", bus.pac_ack, 0);
    check("rst_gh_ack", bus.gh_ack, 0);
    check("rst_col_err", bus.col_err, 0);
    check("rst_ram_wren", bus.ram_wren, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_data", bus.ram_data, 0);
    check("rst_rd_word", bus.rd_word, 0);
    check("rst_rd_cell", bus.rd_cell, 0);
    for (int r = 0; r < 32; r++) preload(r, {$urandom, $urandom, $urandom, $urandom, $urandom});
    #3 rst_n = 1'b1;
    tick();
    rr_last_pac = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      preload(vecs[i].row, set_cell(ref_mem[vecs[i].row], vecs[i].col, 4'(vecs[i].pre)));
      r_row[vecs[i].who] = 5'(vecs[i].row);
      r_col[vecs[i].who] = 6'(vecs[i].col);
      r_we[vecs[i].who]  = vecs[i].we;
      r_wd[vecs[i].who]  = 4'(vecs[i].wd);
      run_round(vecs[i].who == 0, vecs[i].who == 1, vecs[i].who == 2);
      check("vec_latency", ack_cyc[vecs[i].who], vecs[i].exp_lat);
      if (vecs[i].who != 0) check("vec_rd_cell", ack_cell[vecs[i].who], vecs[i].exp_cell);
      check("vec_col_err", ack_err[vecs[i].who], vecs[i].exp_err);
      check("vec_wren", wr_seen, vecs[i].exp_wr);
      check("vec_row_after", mem[vecs[i].row], ref_mem[vecs[i].row]);
    end
    check("plan1_cell5", get_cell(mem[3], 5), 0);

    // Round-robin with both requesters held for four transactions
    do_reset();
    bus.pac_row = 5'd1; bus.pac_col = 6'd0; bus.pac_we = 1'b0;
    bus.gh_row  = 5'd2; bus.gh_col  = 6'd0; bus.gh_we  = 1'b0;
    bus.pac_req = 1'b1;
    bus.gh_req  = 1'b1;
    for (int c = 1; c <= 40 && who_seq.size() < 4; c++) begin
      tick();
      if (bus.pac_ack) begin who_seq.push_back(1); cyc_seq.push_back(c); end
      if (bus.gh_ack)  begin who_seq.push_back(2); cyc_seq.push_back(c); end
    end
    clear_reqs();
    tick();
    rr_last_pac = 1'b0;
    check("rr_count", who_seq.size(), 4);
    for (int i = 0; i < who_seq.size() && i < 4; i++) begin
      check("rr_order", who_seq[i], (i % 2 == 0) ? 1 : 2);
      check("rr_cycle", cyc_seq[i], 3 + 4 * i);
    end

    // vid, pac and gh together on one row: gh must see pac's write
    preload(12, set_cell(ref_mem[12], 8, 4'h3));
    r_row[0] = 5'd12;
    r_row[1] = 5'd12; r_col[1] = 6'd8; r_we[1] = 1'b1; r_wd[1] = 4'hA;
    r_row[2] = 5'd12; r_col[2] = 6'd8; r_we[2] = 1'b0; r_wd[2] = 4'h0;
    run_round(1'b1, 1'b1, 1'b1);
    check("trio_vid_cycle", ack_cyc[0], 3);
    check("trio_pac_cycle", ack_cyc[1], 8);
    check("trio_gh_cycle", ack_cyc[2], 12);
    check("trio_pac_old", ack_cell[1], 4'h3);
    check("trio_gh_sees", ack_cell[2], 4'hA);

    // Reset asserted during WRITE
    preload(5, set_cell(ref_mem[5], 1, 4'h9));
    bus.pac_row = 5'd5; bus.pac_col = 6'd1; bus.pac_we = 1'b1; bus.pac_wdata = 4'h3;
    bus.pac_req = 1'b1;
    repeat (3) tick();
    check("wr_state_wren", bus.ram_wren, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_wren", bus.ram_wren, 0);
    check("abort_ack", bus.pac_ack, 0);
    bus.pac_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    rr_last_pac = 1'b0;
    check("abort_row_kept", mem[5], ref_mem[5]);
    r_row[1] = 5'd5; r_col[1] = 6'd1; r_we[1] = 1'b1; r_wd[1] = 4'h3;
    run_round(1'b0, 1'b1, 1'b0);
    check("post_abort_cycle", ack_cyc[1], 4);
    check("post_abort_old", ack_cell[1], 4'h9);
    check("post_abort_cell", get_cell(mem[5], 1), 4'h3);

    // pac drops its request at cycle 1
    bus.pac_row = 5'd6; bus.pac_col = 6'd2; bus.pac_we = 1'b0;
    bus.pac_req = 1'b1;
    tick();
    bus.pac_req = 1'b0;
    pac_acks = 0;
    pac_cyc = 0;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (bus.pac_ack) begin pac_acks++; pac_cyc = c; end
    end
    rr_last_pac = 1'b1;
    check("drop_ack_count", pac_acks, 1);
    check("drop_ack_cycle", pac_cyc, 3);

    // Randomized rounds on a few rows to force conflicts
    for (int i = 0; i < 40; i++) begin
      en = $urandom_range(1, 7);
      for (int j = 0; j < 3; j++) begin
        r_row[j] = 5'($urandom_range(0, 3));
        r_col[j] = 6'($urandom_range(0, 42));
        r_we[j]  = 1'($urandom_range(0, 1));
        r_wd[j]  = 4'($urandom_range(0, 15));
      end
      run_round(en[0], en[1], en[2]);
    end
    for (int r = 0; r < 32; r++) check("final_map", mem[r], ref_mem[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/map_access_arbiter.md
# map_access_arbiter

Sequencer and arbiter for the single-port map RAM (32 rows × 40 cells × 4 bits). It shares the RAM among three requesters: the video renderer (row reads), the pacman collision logic and the ghost mover (cell read-modify-write). Each transaction is serialized and atomic, so a cell clear from pacman can never be lost under a concurrent ghost update. It sits between the requesters and the RAM instance and is the only block that drives the RAM address, data and write enable.

## Interface
- CELL_W, 4, bits per map cell
- COLS, 40, cells per row; word width W = CELL_W*COLS = 160
- ROW_AW, 5, row address width
- COL_AW, 6, column index width

- CLOCK_50  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  renderer request, held until vid_ack
- vid_row  in  ROW_AW  renderer row
- vid_ack  out  1  one-cycle done pulse
- pac_req, gh_req  in  1  RMW requesters' request, held until own ack
- pac_row, gh_row  in  ROW_AW  target row
- pac_col, gh_col  in  COL_AW  target cell
- pac_we, gh_we  in  1  1 = write wdata into cell; 0 = read only
- pac_wdata, gh_wdata  in  CELL_W  new cell value
- pac_ack, gh_ack  out  1  one-cycle done pulse
- rd_word  out  W  row word as read (before modification); valid during any ack
- rd_cell  out  CELL_W  old value of the addressed cell; valid during pac_ack/gh_ack
- col_err  out  1  pulses with ack when col ≥ COLS
- ram_addr  out  ROW_AW  RAM address
- ram_data  out  W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  W  RAM read data, one cycle after the address is registered

## Operation
- Cell c occupies word bits [W-1-CELL_W*c -: CELL_W]; cell 0 is at the MSBs.
- FSM states: IDLE, ADDR, DATA, WRITE, ACK.
- IDLE: if any request is present, latch the winner's id, row, col, we and wdata, then go to ADDR.
- Priority: vid_req always wins. pac and gh are round-robin: when both are pending, the one not served last wins. After reset, pac has priority.
- ADDR: ram_addr = latched row, ram_wren = 0.
- DATA: capture ram_q into rd_word and the addressed cell into rd_cell. Go to WRITE if we = 1 and col < COLS, else go to ACK.
- WRITE: ram_addr = row, ram_data = captured word with only the addressed cell replaced by wdata, ram_wren = 1. Then go to ACK.
- ACK: pulse the winner's ack for one cycle, with col_err = (col ≥ COLS). Then return to IDLE.
- When col ≥ COLS: no write, rd_cell = 0.
- Renderer transactions are always read-only.
- Latched request fields are frozen for the whole transaction; input changes after the IDLE sample are ignored.
- If a requester drops req mid-transaction, the transaction still completes and ack still pulses.
- A requester that keeps req high after its ack starts a new transaction; it re-competes in IDLE.

## Timing
- Async reset (reset_n low):
  - state = IDLE; all acks, col_err and ram_wren = 0 immediately.
  - ram_addr = 0, ram_data = 0, rd_word = 0, rd_cell = 0; round-robin pointer favors pac.
  - A write in progress is aborted. RAM contents are never cleared by this block.
- Request sampled high in IDLE at cycle 0:
  - read: ADDR at cycle 1, DATA at 2, ack at 3.
  - write: WRITE (ram_wren high) at cycle 3, ack at 4.
- Minimum spacing between acks: 4 cycles (reads), 5 cycles (writes). IDLE always lasts at least one cycle.
- ram_wren is high exactly one cycle per write transaction and never outside WRITE.
- Simultaneous requests in the same IDLE cycle are served in this order: vid first, then pac/gh per round-robin. No request is dropped.
- Worst-case pac/gh wait: vid is unbounded by design. The renderer duty cycle is guaranteed to be below 50% by the video timing.

## Test plan
- Reset, preload row 3 cell 5 = 2, pac_req row 3 col 5 we=1 wdata=0 → pac_ack at cycle 4, rd_cell=2, ram_wren one cycle, row 3 reads back with cell 5 = 0 and all other cells unchanged.
- pac_req and gh_req raised in the same cycle, both held, for 4 transactions → serve order pac, gh, pac, gh.
- vid_req, pac_req and gh_req raised together → vid_ack at cycle 3 (no write). The pac write follows; then gh's transaction re-reads the row and sees pac's update.
- gh_req col=40 we=1 → gh_ack with col_err=1, rd_cell=0, ram_wren never asserted.
- Assert reset_n low during the WRITE state → ram_wren and ack drop asynchronously, FSM is in IDLE after release, and a subsequent pac_req completes normally.
- pac_req dropped at cycle 1 → pac_ack still pulses at cycle 3 (read) and no spurious second transaction occurs.
